// File: rtl/rect_pkg.sv
// rect_pkg: shared state encoding and screen/rectangle geometry for the rectangle demo.
package rect_pkg;
    typedef enum logic [1:0] {FOLLOW = 2'd0, FALL = 2'd1, REST = 2'd2} state_t;
    localparam int VISIBLE_WIDTH  = 800;
    localparam int VISIBLE_HEIGHT = 600;
    localparam int RECT_WIDTH     = 48;
    localparam int RECT_HEIGHT    = 64;
endpackage

// File: rtl/edge_rise.sv
// edge_rise: rising-edge detector against a registered copy with selectable reset value.
module edge_rise #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);
    logic d_q;
    always_ff @(posedge clk) d_q <= rst ? RST_VAL : d;
    assign rise = d & ~d_q;
endmodule

// File: rtl/rect_motion_sched.sv
// rect_motion_sched: per-frame FOLLOW/FALL/REST sequencer for the rectangle position.
module rect_motion_sched
    import rect_pkg::*;
#(
    parameter int GRAVITY    = 1,
    parameter int DAMP_SHIFT = 1,
    parameter int MIN_BOUNCE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblank,
    input  logic        mouse_left,
    input  logic [11:0] mouse_x,
    input  logic [11:0] mouse_y,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state,
    output logic        bounce,
    output logic        landed
);
    localparam logic [11:0]        FLOOR   = 12'(VISIBLE_HEIGHT - RECT_HEIGHT);
    localparam logic [11:0]        XMAX    = 12'(VISIBLE_WIDTH - RECT_WIDTH);
    localparam logic signed [12:0] FLOOR_S = 13'(VISIBLE_HEIGHT - RECT_HEIGHT);
    localparam logic signed [11:0] GRAV    = 12'(GRAVITY);
    localparam logic signed [11:0] MIN_B   = 12'(MIN_BOUNCE);
    state_t             st, st_n;
    logic signed [11:0] vel, vel_n, r;
    logic signed [12:0] ynew;
    logic [11:0]        xpos_n, ypos_n;
    logic               bounce_n, landed_n, tick, click;
    edge_rise #(.RST_VAL(1'b0)) u_tick  (.clk(clk), .rst(rst), .d(vblank),     .rise(tick));
    // Delay flop resets high so a button held through reset is not a click.
    edge_rise #(.RST_VAL(1'b1)) u_click (.clk(clk), .rst(rst), .d(mouse_left), .rise(click));
    assign ynew  = $signed({1'b0, ypos}) + $signed({vel[11], vel});
    assign r     = vel - (vel >>> DAMP_SHIFT);
    assign state = st;
    always_comb begin
        st_n     = st;
        xpos_n   = xpos;
        ypos_n   = ypos;
        vel_n    = vel;
        bounce_n = 1'b0;
        landed_n = 1'b0;
        case (st)
            FOLLOW: if (click) begin
                st_n  = FALL;
                vel_n = '0;
            end else begin
                xpos_n = mouse_x > XMAX ? XMAX : mouse_x;
                ypos_n = mouse_y > FLOOR ? FLOOR : mouse_y;
            end
            FALL: if (tick) begin
                if (ynew >= FLOOR_S) begin
                    ypos_n = FLOOR;
                    if (r >= MIN_B) begin
                        vel_n    = -r;
                        bounce_n = 1'b1;
                    end else begin
                        vel_n    = '0;
                        st_n     = REST;
                        landed_n = 1'b1;
                    end
                end else if (ynew[12]) begin
                    ypos_n = '0;
                    vel_n  = '0;
                end else begin
                    ypos_n = ynew[11:0];
                    vel_n  = vel + GRAV;
                end
            end
            REST: begin
                vel_n = '0;
                if (click) st_n = FOLLOW;
            end
            default: st_n = FOLLOW;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= FOLLOW;
            xpos   <= '0;
            ypos   <= '0;
            vel    <= '0;
            bounce <= 1'b0;
            landed <= 1'b0;
        end else begin
            st     <= st_n;
            xpos   <= xpos_n;
            ypos   <= ypos_n;
            vel    <= vel_n;
            bounce <= bounce_n;
            landed <= landed_n;
        end
    end
endmodule

// File: tb/tb_rect_motion_sched.sv
// tb_rect_motion_sched: directed checks of tracking, bounce physics, clicks and reset.
module tb_rect_motion_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblank = 1'b0;
    logic        mouse_left = 1'b0;
    logic [11:0] mouse_x = '0;
    logic [11:0] mouse_y = '0;
    logic [11:0] xpos, ypos;
    logic [1:0]  state;
    logic        bounce, landed;
    int checks = 0;
    int failures = 0;

    rect_motion_sched dut (
        .clk(clk), .rst(rst), .vblank(vblank), .mouse_left(mouse_left),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .xpos(xpos), .ypos(ypos),
        .state(state), .bounce(bounce), .landed(landed)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_edge();
        vblank = 1'b0;
        cyc();
        vblank = 1'b1;
        cyc();
        vblank = 1'b0;
    endtask

    task automatic click_edge();
        mouse_left = 1'b0;
        cyc();
        mouse_left = 1'b1;
        cyc();
        mouse_left = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mouse_left = 1'b0;
        cyc();
        cyc();
        checks++; if (xpos !== 12'd0) begin failures++; $display("FAIL reset_xpos got=%0d exp=0", xpos); end
        checks++; if (ypos !== 12'd0) begin failures++; $display("FAIL reset_ypos got=%0d exp=0", ypos); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
        checks++; if ({bounce, landed} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {bounce, landed}); end
        rst = 1'b0;
    endtask

    task automatic test_follow_clamp();
        logic [11:0] vx[4] = '{12'd900, 12'd100, 12'd752, 12'd753};
        logic [11:0] vy[4] = '{12'd700, 12'd200, 12'd536, 12'd537};
        logic [11:0] ex[4] = '{12'd752, 12'd100, 12'd752, 12'd752};
        logic [11:0] ey[4] = '{12'd536, 12'd200, 12'd536, 12'd536};
        for (int i = 0; i < 4; i++) begin
            mouse_x = vx[i];
            mouse_y = vy[i];
            cyc();
            checks++; if (xpos !== ex[i]) begin failures++; $display("FAIL follow_x[%0d] got=%0d exp=%0d", i, xpos, ex[i]); end
            checks++; if (ypos !== ey[i]) begin failures++; $display("FAIL follow_y[%0d] got=%0d exp=%0d", i, ypos, ey[i]); end
        end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL follow_state got=%0d exp=0", state); end
    endtask

    task automatic test_drop();
        int ey[23] = '{500, 501, 503, 506, 510, 515, 521, 528, 536, 532, 529, 527,
                       526, 526, 527, 529, 532, 536, 534, 533, 533, 534, 536};
        mouse_x = 12'd300;
        mouse_y = 12'd500;
        cyc();
        click_edge();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL drop_enter_fall got=%0d exp=1", state); end
        checks++; if (ypos !== 12'd500) begin failures++; $display("FAIL drop_hold_y got=%0d exp=500", ypos); end
        mouse_x = 12'd10;
        mouse_y = 12'd10;
        for (int t = 1; t <= 23; t++) begin
            tick_edge();
            checks++; if (ypos !== 12'(ey[t-1])) begin failures++; $display("FAIL drop_y[tick %0d] got=%0d exp=%0d", t, ypos, ey[t-1]); end
            checks++; if (bounce !== (t == 9 || t == 18)) begin failures++; $display("FAIL drop_bounce[tick %0d] got=%b", t, bounce); end
            checks++; if (landed !== (t == 23)) begin failures++; $display("FAIL drop_landed[tick %0d] got=%b", t, landed); end
            checks++; if (state !== (t == 23 ? 2'd2 : 2'd1)) begin failures++; $display("FAIL drop_state[tick %0d] got=%0d", t, state); end
            checks++; if (xpos !== 12'd300) begin failures++; $display("FAIL drop_x[tick %0d] got=%0d exp=300", t, xpos); end
            if (t == 9) begin
                checks++; if (dut.vel !== -12'sd4) begin failures++; $display("FAIL drop_vel9 got=%0d exp=-4", $signed(dut.vel)); end
            end
            if (t == 18) begin
                checks++; if (dut.vel !== -12'sd2) begin failures++; $display("FAIL drop_vel18 got=%0d exp=-2", $signed(dut.vel)); end
            end
        end
        cyc();
        checks++; if ({bounce, landed} !== 2'b00) begin failures++; $display("FAIL drop_pulse_width got=%b exp=00", {bounce, landed}); end
    endtask

    task automatic test_pickup();
        mouse_x = 12'd40;
        mouse_y = 12'd60;
        click_edge();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL pickup_state got=%0d exp=0", state); end
        checks++; if (ypos !== 12'd536) begin failures++; $display("FAIL pickup_hold_y got=%0d exp=536", ypos); end
        cyc();
        checks++; if (xpos !== 12'd40) begin failures++; $display("FAIL pickup_x got=%0d exp=40", xpos); end
        checks++; if (ypos !== 12'd60) begin failures++; $display("FAIL pickup_y got=%0d exp=60", ypos); end
    endtask

    // Drop from y=530 reaches REST after 9 ticks.
    task automatic test_short_drop();
        int n = 0;
        mouse_x = 12'd123;
        mouse_y = 12'd530;
        cyc();
        click_edge();
        while (state != 2'd2 && n < 50) begin
            tick_edge();
            n++;
        end
        checks++; if (n !== 9) begin failures++; $display("FAIL short_drop_ticks got=%0d exp=9", n); end
        checks++; if (ypos !== 12'd536) begin failures++; $display("FAIL short_drop_y got=%0d exp=536", ypos); end
    endtask

    task automatic test_tick_click_rest();
        vblank = 1'b0;
        mouse_left = 1'b0;
        mouse_x = 12'd5;
        mouse_y = 12'd5;
        cyc();
        vblank = 1'b1;
        mouse_left = 1'b1;
        cyc();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rest_tc_state got=%0d exp=0", state); end
        checks++; if (ypos !== 12'd536) begin failures++; $display("FAIL rest_tc_y got=%0d exp=536", ypos); end
        checks++; if ({bounce, landed} !== 2'b00) begin failures++; $display("FAIL rest_tc_pulses got=%b exp=00", {bounce, landed}); end
        vblank = 1'b0;
        mouse_left = 1'b0;
    endtask

    task automatic test_vblank_held();
        int changes = 0;
        logic [11:0] prev;
        mouse_x = 12'd50;
        mouse_y = 12'd100;
        cyc();
        click_edge();
        for (int i = 0; i < 3; i++) tick_edge();
        checks++; if (ypos !== 12'd103) begin failures++; $display("FAIL held_pre_y got=%0d exp=103", ypos); end
        vblank = 1'b0;
        cyc();
        prev = ypos;
        vblank = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            mouse_left = i[0];
            cyc();
            if (ypos != prev) changes++;
            prev = ypos;
        end
        vblank = 1'b0;
        mouse_left = 1'b0;
        checks++; if (changes !== 1) begin failures++; $display("FAIL held_changes got=%0d exp=1", changes); end
        checks++; if (ypos !== 12'd106) begin failures++; $display("FAIL held_y got=%0d exp=106", ypos); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL held_state got=%0d exp=1", state); end
        checks++; if (xpos !== 12'd50) begin failures++; $display("FAIL held_x got=%0d exp=50", xpos); end
    endtask

    task automatic test_reset_midfall();
        tick_edge();
        mouse_left = 1'b1;
        mouse_x = 12'd200;
        mouse_y = 12'd300;
        rst = 1'b1;
        cyc();
        checks++; if (xpos !== 12'd0 || ypos !== 12'd0) begin failures++; $display("FAIL midrst_pos got=%0d,%0d exp=0,0", xpos, ypos); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL midrst_state got=%0d exp=0", state); end
        checks++; if (dut.vel !== 12'sd0) begin failures++; $display("FAIL midrst_vel got=%0d exp=0", $signed(dut.vel)); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL held_button_state got=%0d exp=0", state); end
        checks++; if (xpos !== 12'd200 || ypos !== 12'd300) begin failures++; $display("FAIL held_button_pos got=%0d,%0d exp=200,300", xpos, ypos); end
        click_edge();
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL reclick_state got=%0d exp=1", state); end
    endtask

    initial begin
        test_reset();
        test_follow_clamp();
        test_drop();
        test_pickup();
        test_short_drop();
        test_tick_click_rest();
        test_vblank_held();
        test_reset_midfall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
